// File: rtl/pixel_pack_16to32.sv
// pixel_pack_16to32: packs RGB565 pixel pairs into 32-bit words and queues
// them in a first-word-fall-through FIFO for the frame-memory writer.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   HOLD_NONE | no pixel held; next pixel becomes the low half
//   HOLD_LOW  | low_q holds the first pixel of a pair
module pixel_pack_16to32 #(
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     burst_avail
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] BURST_LVL = LW'(BURST);

  typedef enum logic {
    HOLD_NONE = 1'b0,
    HOLD_LOW  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    low_q, low_d;
  logic [32:0]    mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [LW-1:0]  level_q, level_d;
  logic           burst_q;

  logic           full, empty, accept, pop, push;
  logic [32:0]    push_word;
  logic [32:0]    head;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  // Ready depends only on registered level, never on out_ready.
  assign in_ready  = ~full & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  // Data outputs are forced to zero when nothing is queued so that the
  // head of a stale or reset entry never shows.
  assign head        = mem_q[rptr_q];
  assign out_data    = out_valid ? head[31:0] : 32'h0;
  assign out_last    = out_valid & head[32];
  assign level       = level_q;
  assign burst_avail = burst_q;

  // Packer next state: pair pixels, pad an odd last pixel with zeros.
  always_comb begin
    state_d   = state_q;
    low_d     = low_q;
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      HOLD_NONE: begin
        if (accept) begin
          if (in_last) begin
            push      = 1'b1;
            push_word = {1'b1, 16'h0000, in_data};
          end else begin
            low_d   = in_data;
            state_d = HOLD_LOW;
          end
        end
      end
      HOLD_LOW: begin
        if (accept) begin
          push      = 1'b1;
          push_word = {in_last, in_data, low_q};
          state_d   = HOLD_NONE;
        end
      end
      default: state_d = HOLD_NONE;
    endcase
  end

  // Occupancy counter: simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Packer state and held low pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD_NONE;
      low_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
    end
  end

  // FIFO storage and naturally wrapping pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_word;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Registered status, updated on the same edge as the push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      burst_q <= 1'b0;
    end else begin
      level_q <= level_d;
      burst_q <= (level_d >= BURST_LVL);
    end
  end

endmodule

// File: doc/pixel_pack_16to32.md
# pixel_pack_16to32

Width upconverter and elastic buffer on the camera capture path. It accepts 16-bit RGB565 pixels with a valid/ready handshake and packs each pixel pair into one 32-bit word. Packed words are queued in a small FIFO and presented with valid/ready to the 32-bit frame-memory writer. It is the mirror of the 32-to-16 line-buffer read path: a 32-bit word built here, read back 16 bits at a time, returns pixels in their original order.

## Interface
- DEPTH, 8, FIFO depth in 32-bit words; power of two, ≥ 2.
- BURST, 4, `burst_avail` threshold in words; 1 ≤ BURST ≤ DEPTH.
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  16  pixel (RGB565).
- in_valid  input  1  `in_data` / `in_last` are valid.
- in_last  input  1  pixel is the last of its line.
- in_ready  output  1  block accepts a pixel this cycle.
- out_data  output  32  packed word; first pixel in [15:0], second in [31:16].
- out_valid  output  1  `out_data` / `out_last` are valid.
- out_last  output  1  word contains the line's last pixel.
- out_ready  input  1  downstream consumes the word this cycle.
- level  output  $clog2(DEPTH)+1  number of words in the FIFO.
- burst_avail  output  1  `level >= BURST`.

## Operation
- **Handshakes.** Input accept = `in_valid & in_ready`. Output pop = `out_valid & out_ready`.
- **Packer FSM.** Two states, HOLD_NONE and HOLD_LOW. It also has a 16-bit `low_reg`.
  - HOLD_NONE, accept with `in_last=0`: latch `in_data` into `low_reg`; go to HOLD_LOW. No push.
  - HOLD_NONE, accept with `in_last=1`: push {16'h0000, in_data} with last=1; stay in HOLD_NONE. This is the odd-length line pad.
  - HOLD_LOW, accept: push {in_data, low_reg} with last=in_last; go to HOLD_NONE.
  - No accept: hold state.
- **Input ready.** `in_ready = ~full & ~reset`. This is conservative: it is low whenever the FIFO is full, even in HOLD_NONE.
  - There is no combinational path from `out_ready` to `in_ready`.
  - A pop in the same cycle does not raise `in_ready`.
- **FIFO.** DEPTH × 33 bits (data + last), register-based, first-word-fall-through.
  - `out_data` / `out_last` reflect the head entry whenever `out_valid=1`.
- **Pointers.** `$clog2(DEPTH)`-bit read and write pointers that wrap naturally.
  - `level` is tracked by a counter: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
  - `full = (level == DEPTH)`, `empty = (level == 0)`.
- **Underflow and overflow.** Neither can occur.
  - Pop requires `out_valid`, which is `~empty`.
  - Push requires an accept, which requires `~full`.
- **Output hold.** While `out_valid=1 & out_ready=0`, `out_data` and `out_last` stay stable.
- **Data width.** Data is never modified except for the zero pad in the odd-pixel case.

## Timing
- **Reset values** (asynchronous, immediate on `reset` assertion):
  - FSM = HOLD_NONE, `low_reg` = 0, pointers = 0, `level` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `burst_avail` = 0, `in_ready` = 0.
- **Release from reset.** `in_ready` = 1 from the first clock after `reset` is released.
- **Reset mid-line.** A half-held pixel in `low_reg` and all queued words are discarded. No partial word is emitted.
- **Latency.** A word pushed at rising edge N gives `out_valid` = 1 with that word in the cycle after edge N. That is one clock from the accept of the completing pixel to the output.
- **Throughput.** One pixel per clock on input and one word per clock on output. Sustained input needs out bandwidth ≥ half the input rate.
- **Status outputs.** `level` and `burst_avail` are registered and update on the same edge as the push or pop.
- **Full FIFO, simultaneous events.** Input is stalled that cycle. The pop frees a slot, and `in_ready` rises the next cycle.
- **Empty FIFO, simultaneous events.** A push with no pop makes `out_valid` = 1 the next cycle. A push and pop in the same cycle cannot occur, because `out_valid` was 0.

## Test plan
- **Basic pack.** After reset, send 0x1111, 0x2222 (last=0), then 0x3333, 0x4444 (last=1), `out_ready`=1.
  - Required: 0x22221111 last=0, then 0x44443333 last=1.
  - Required: each word appears one cycle after its second pixel is accepted.
- **Odd line.** Send 0xAAAA, 0xBBBB, then 0xCCCC with last=1.
  - Required: 0xBBBBAAAA last=0, then 0x0000CCCC last=1.
  - Required: the next pixel 0xDDDD lands in the low half of a new word.
- **Full/backpressure** (DEPTH=8). Hold `out_ready`=0 and stream 20 pixels.
  - Required: `in_ready` drops after 16 accepted pixels, with `level`=8 and `burst_avail`=1.
  - Then assert `out_ready`. Required: all 10 words emerge in order, with no loss or duplication.
- **Simultaneous push+pop at full.** Hold the FIFO full, then assert `out_ready` for one cycle with `in_valid`=1.
  - Required: `level` becomes 7 and no pixel is accepted that cycle.
  - Required: `in_ready`=1 the next cycle.
- **Wrap-around.** Random valid/ready stalls for 1000 pixels across multiple pointer wraps.
  - Required: the output matches the scoreboard, and `level` is never > 8 or < 0.
- **Reset mid-operation.** Assert `reset` while holding one pixel with 3 words queued.
  - Required: `out_valid`=0, `level`=0 and `in_ready`=0 immediately.
  - Required: after release, the next two pixels form a fresh word with no stale data.
